// File: rtl/adc_pkg.sv
// Shared constants for the ADC capture controller: default widths, FSM state
// encodings and trigger source codes.
package adc_pkg;

  localparam int ADC_DATA_W = 10;
  localparam int ADC_ADDR_W = 10;
  localparam int ADC_DEPTH  = 1024;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRE       = 3'd1;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] ST_POST      = 3'd3;
  localparam logic [2:0] ST_LOCKED    = 3'd4;

  typedef enum logic [1:0] {
    TRIG_IMM = 2'd0,
    TRIG_CH0 = 2'd1,
    TRIG_CH1 = 2'd2,
    TRIG_CH2 = 2'd3
  } trig_src_e;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Sample-buffer write port driven by the capture controller; the controller
// owns the master side, the buffer RAM (or a bench) the slave side.
interface adc_capture_ctrl_if
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int ADDR_W = ADC_ADDR_W
);

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [3*DATA_W-1:0]   wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/adc_edge_trigger.sv
// Rising-edge trigger detector: remembers the previous written sample of the
// selected channel and flags a crossing of the threshold on the current one.
module adc_edge_trigger
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] ad0_i,
  input  logic [DATA_W-1:0] ad1_i,
  input  logic [DATA_W-1:0] ad2_i,
  input  trig_src_e         src_i,
  input  logic [DATA_W-1:0] level_i,
  output logic              fire_o
);

  logic [DATA_W-1:0] curSample;
  logic [DATA_W-1:0] prevSample_q, prevSample_d;
  logic              prevValid_q, prevValid_d;

  always_comb begin
    case (src_i)
      TRIG_CH1: curSample = ad1_i;
      TRIG_CH2: curSample = ad2_i;
      default:  curSample = ad0_i;
    endcase
  end

  // Immediate mode fires on any sample; the caller qualifies with its state.
  assign fire_o = (src_i == TRIG_IMM) ||
                  (prevValid_q && (prevSample_q < level_i) && (curSample >= level_i));

  always_comb begin
    prevSample_d = prevSample_q;
    prevValid_d  = prevValid_q;
    if (clear_i) begin
      prevValid_d = 1'b0;
    end else if (capture_i) begin
      prevSample_d = curSample;
      prevValid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevSample_q <= '0;
      prevValid_q  <= 1'b0;
    end else begin
      prevSample_q <= prevSample_d;
      prevValid_q  <= prevValid_d;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: pre-trigger fill, ring overwrite while waiting for the
// trigger, post-trigger fill, then hold the frame until readout completes.
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int ADDR_W = ADC_ADDR_W,
  parameter int DEPTH  = ADC_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] ad0_data,
  input  logic [DATA_W-1:0] ad1_data,
  input  logic [DATA_W-1:0] ad2_data,
  input  logic [2:0]        ad_otr,
  input  logic              arm,
  input  logic              abort,
  input  logic              rd_done,
  input  logic [1:0]        trig_src,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W-1:0] pre_len,
  adc_capture_ctrl_if.master wr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              frame_ready,
  output logic              ovr_flag,
  output logic [2:0]        state_o
);

  localparam logic [ADDR_W:0] DepthC = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] OneC   = (ADDR_W+1)'(1);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                lastWrite_q, lastWrite_d;
  trig_src_e           trigSrc_q, trigSrc_d;
  logic [DATA_W-1:0]   trigLevel_q, trigLevel_d;
  logic [ADDR_W-1:0]   preLen_q, preLen_d;
  logic [ADDR_W-1:0]   startAddr_q, startAddr_d;
  logic                ovr_q, ovr_d;
  logic                wrEn_q, wrEn_d;
  logic [ADDR_W-1:0]   wrAddr_q, wrAddr_d;
  logic [3*DATA_W-1:0] wrData_q, wrData_d;

  logic            capturing;
  logic            capture;
  logic            armAccept;
  logic            fire;
  logic [ADDR_W:0] postLen;

  assign capturing = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
  // Once the final post-trigger sample is taken, nothing else is written.
  assign capture   = sample_en && !abort && !lastWrite_q && capturing;
  assign armAccept = arm && !abort && (state_q == ST_IDLE);
  assign postLen   = DepthC - {1'b0, preLen_q};

  adc_edge_trigger #(.DATA_W(DATA_W)) u_trig (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (armAccept),
    .capture_i (capture),
    .ad0_i     (ad0_data),
    .ad1_i     (ad1_data),
    .ad2_i     (ad2_data),
    .src_i     (trigSrc_q),
    .level_i   (trigLevel_q),
    .fire_o    (fire)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    lastWrite_d = lastWrite_q;
    trigSrc_d   = trigSrc_q;
    trigLevel_d = trigLevel_q;
    preLen_d    = preLen_q;
    startAddr_d = startAddr_q;
    ovr_d       = ovr_q;
    wrEn_d      = capture;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;

    if (capture) begin
      wrAddr_d = ptr_q;
      wrData_d = {ad2_data, ad1_data, ad0_data};
      ptr_d    = ptr_q + 1'b1;
      ovr_d    = ovr_q | (|ad_otr);
    end

    if (abort) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      lastWrite_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            trigSrc_d   = trig_src_e'(trig_src);
            trigLevel_d = trig_level;
            preLen_d    = pre_len;
            ovr_d       = 1'b0;
            cnt_d       = '0;
            state_d     = (pre_len == '0) ? ST_WAIT_TRIG : ST_PRE;
          end
        end
        ST_PRE: begin
          if (capture) begin
            if ((cnt_q + 1'b1) == {1'b0, preLen_q}) begin
              state_d = ST_WAIT_TRIG;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_WAIT_TRIG: begin
          // The trigger sample itself is the first post-trigger sample.
          if (capture && fire) begin
            startAddr_d = ptr_q - preLen_q;
            cnt_d       = OneC;
            state_d     = ST_POST;
            lastWrite_d = (postLen == OneC);
          end
        end
        ST_POST: begin
          if (lastWrite_q) begin
            state_d     = ST_LOCKED;
            lastWrite_d = 1'b0;
            cnt_d       = '0;
          end else if (capture) begin
            cnt_d = cnt_q + 1'b1;
            if ((cnt_q + 1'b1) == postLen) begin
              lastWrite_d = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (rd_done) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      lastWrite_q <= 1'b0;
      trigSrc_q   <= TRIG_IMM;
      trigLevel_q <= '0;
      preLen_q    <= '0;
      startAddr_q <= '0;
      ovr_q       <= 1'b0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      lastWrite_q <= lastWrite_d;
      trigSrc_q   <= trigSrc_d;
      trigLevel_q <= trigLevel_d;
      preLen_q    <= preLen_d;
      startAddr_q <= startAddr_d;
      ovr_q       <= ovr_d;
      wrEn_q      <= wrEn_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
    end
  end

  assign wr.wr_en    = wrEn_q;
  assign wr.wr_addr  = wrAddr_q;
  assign wr.wr_data  = wrData_q;
  assign start_addr  = startAddr_q;
  assign frame_ready = (state_q == ST_LOCKED);
  assign ovr_flag    = ovr_q;
  assign state_o     = state_q;

endmodule
